// File: rtl/mul_pow2_seq.sv
// rtl/mul_pow2_seq.sv - iterative signed x*2^y, one left shift per clock, ready/valid/ack handshake
// Define MUL_POW2_SATURATE_EN to saturate on overflow; otherwise the result wraps.
module mul_pow2_seq #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [W-1:0]  x_i,
    input  logic [SW-1:0] y_i,
    output logic          ready_o,
    output logic          valid_o,
    input  logic          ack_i,
    output logic [W-1:0]  result_o,
    output logic          overflow_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [SW-1:0] cnt;
    logic          ovf;
    logic [W-1:0]  result_q;
    logic          overflow_q;
    logic          step_ovf;
    logic [W-1:0]  shifted;
    logic [W-1:0]  final_val;

    // Doubling overflows exactly when the two top bits disagree before the shift.
    assign step_ovf = ovf | (acc[W-1] ^ acc[W-2]);
    assign shifted  = {acc[W-2:0], 1'b0};

`ifdef MUL_POW2_SATURATE_EN
    logic neg;
    assign final_val = step_ovf ? (neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                : shifted;
`else
    assign final_val = shifted;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
`ifdef MUL_POW2_SATURATE_EN
            neg        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc <= x_i;
                        cnt <= y_i;
                        ovf <= 1'b0;
`ifdef MUL_POW2_SATURATE_EN
                        neg <= x_i[W-1];
`endif
                        if (y_i == '0) begin
                            state      <= DONE;
                            result_q   <= x_i;
                            overflow_q <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - 1'b1;
                    ovf <= step_ovf;
                    if (cnt == SW'(1)) begin
                        state      <= DONE;
                        result_q   <= final_val;
                        overflow_q <= step_ovf;
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mul_pow2_seq.sv
// tb/tb_mul_pow2_seq.sv - randomized and exhaustive self-checking bench for mul_pow2_seq
module tb_mul_pow2_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] x_i;
    logic [2:0] y_i;
    logic       ready_o;
    logic       valid_o;
    logic       ack_i;
    logic [7:0] result_o;
    logic       overflow_o;

    int n_tests = 0;
    int n_fail  = 0;
    int last_res = 0;

    mul_pow2_seq #(.W(8), .SW(3)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .x_i        (x_i),
        .y_i        (y_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ack_i      (ack_i),
        .result_o   (result_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int res_s();
        logic signed [7:0] r;
        r = result_o;
        return int'(r);
    endfunction

    // Reference: true product, range test, then clamp or reduce modulo 256.
    task automatic model(input int x, input int y, output int r, output int ov);
        int p;
        p  = x * (2 ** y);
        ov = (p > 127 || p < -128) ? 1 : 0;
`ifdef MUL_POW2_SATURATE_EN
        r = ov ? ((x < 0) ? -128 : 127) : p;
`else
        r = ((p % 256) + 256) % 256;
        if (r > 127) r = r - 256;
`endif
    endtask

    task automatic do_op(input int x, input int y, input int hold, input bit noise);
        int exp_r, exp_ov, lat;
        model(x, y, exp_r, exp_ov);
        @(negedge clk_i);
        check("ready_before_start", int'(ready_o), 1);
        start_i = 1'b1;
        x_i     = 8'(x);
        y_i     = 3'(y);
        lat     = 0;
        do begin
            @(negedge clk_i);
            lat++;
            start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            x_i     = noise ? 8'd7 : x_i;
            y_i     = noise ? 3'($urandom) : y_i;
            ack_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!valid_o && lat <= 8) begin
                check("result_retained", res_s(), last_res);
                check("ready_low_busy", int'(ready_o), 0);
            end
        end while (!valid_o && lat <= 20);
        ack_i = 1'b0;
        check("latency", lat, y + 1);
        check("result", res_s(), exp_r);
        check("overflow", int'(overflow_o), exp_ov);
        check("ready_low_done", int'(ready_o), 0);
        for (int k = 0; k < hold; k++) begin
            start_i = noise ? 1'b1 : 1'b0;
            x_i     = 8'd7;
            @(negedge clk_i);
            check("hold_valid", int'(valid_o), 1);
            check("hold_result", res_s(), exp_r);
            check("hold_overflow", int'(overflow_o), exp_ov);
        end
        ack_i   = 1'b1;
        start_i = 1'b1;
        x_i     = 8'd7;
        y_i     = 3'd0;
        @(negedge clk_i);
        ack_i   = 1'b0;
        start_i = 1'b0;
        check("valid_after_ack", int'(valid_o), 0);
        check("ready_after_ack", int'(ready_o), 1);
        check("result_after_ack", res_s(), exp_r);
        last_res = exp_r;
    endtask

    initial begin
        int hold;
        rst_i   = 1'b1;
        start_i = 1'b0;
        ack_i   = 1'b0;
        x_i     = '0;
        y_i     = '0;
        #12;
        check("reset_ready", int'(ready_o), 1);
        check("reset_valid", int'(valid_o), 0);
        check("reset_result", res_s(), 0);
        check("reset_overflow", int'(overflow_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op(3, 2, 0, 1'b0);
        do_op(-5, 3, 1, 1'b1);
        do_op(-64, 1, 0, 1'b0);
        do_op(100, 1, 2, 1'b1);
        do_op(1, 7, 0, 1'b1);
        do_op(-65, 1, 0, 1'b0);
        do_op(-128, 0, 5, 1'b1);
        do_op(0, 7, 0, 1'b0);

        // Abandon an operation mid-shift; reset must act without a clock edge.
        @(negedge clk_i);
        start_i = 1'b1;
        x_i     = 8'd9;
        y_i     = 3'd6;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("midreset_ready", int'(ready_o), 1);
        check("midreset_valid", int'(valid_o), 0);
        check("midreset_result", res_s(), 0);
        check("midreset_overflow", int'(overflow_o), 0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        last_res = 0;
        do_op(2, 2, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            hold = $urandom_range(0, 3);
            do_op($signed(8'($urandom)), $urandom_range(0, 7), hold, 1'b1);
        end

        for (int x = -128; x <= 127; x++) begin
            for (int y = 0; y <= 7; y++) begin
                do_op(x, y, 0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
